// File: rtl/rr_grant_scheduler.sv
// rr_grant_scheduler
//   Eight-requester round-robin scheduler that owns a shared 8-to-3 encoder
//   resource. One requester is granted at a time and may keep the grant for
//   at most MAX_HOLD consecutive cycles. When the grant is released, a new
//   winner is chosen in the same cycle, so there is no idle bubble.
//
// Ports
//   clk        : system clock, all state changes on the rising edge
//   rst_n      : synchronous active-low reset
//   en         : scheduler enable; low blocks new grants and drops the current one
//   req        : level-sensitive request vector, bit i = requester i
//   gnt        : registered one-hot grant, zero when nothing is granted
//   gnt_id     : registered binary index of the grant, holds when gnt_valid=0
//   gnt_valid  : registered flag, high while a grant is active
module rr_grant_scheduler #(
  parameter int N_REQ    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic                     gnt_valid
);

  localparam int IDW = $clog2(N_REQ);
  localparam int HCW = $clog2(MAX_HOLD) + 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t           state;
  logic [IDW-1:0]   ptr;
  logic [HCW-1:0]   hold_cnt;

  logic [IDW-1:0]   next_after;
  logic [IDW-1:0]   search_base;
  logic [IDW-1:0]   pick_idx;
  logic             pick_found;
  logic             hold_ok;

  // The holder keeps the resource only while enabled, still requesting and
  // below its hold budget. With MAX_HOLD=1 the budget test is always false,
  // so the grant rotates every cycle.
  assign hold_ok    = en && req[gnt_id] && (hold_cnt < HOLD_LAST);
  assign next_after = gnt_id + IDW'(1);

  // From IDLE the search starts at the round-robin pointer; on a release it
  // starts just past the holder, which makes the holder the last candidate.
  assign search_base = (state == IDLE) ? ptr : next_after;

  always_comb begin
    logic [IDW-1:0] idx;
    pick_idx   = '0;
    pick_found = 1'b0;
    idx        = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = search_base + IDW'(i);
      if (!pick_found && req[idx]) begin
        pick_found = 1'b1;
        pick_idx   = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en && pick_found) begin
            state     <= GRANT;
            hold_cnt  <= '0;
            gnt       <= N_REQ'(1) << pick_idx;
            gnt_id    <= pick_idx;
            gnt_valid <= 1'b1;
          end
        end
        GRANT: begin
          if (hold_ok) begin
            hold_cnt <= hold_cnt + HCW'(1);
          end else begin
            // Release: advance the pointer past the holder and hand over
            // immediately if anyone qualifies; en low forbids a re-grant.
            ptr <= next_after;
            if (en && pick_found) begin
              hold_cnt  <= '0;
              gnt       <= N_REQ'(1) << pick_idx;
              gnt_id    <= pick_idx;
              gnt_valid <= 1'b1;
            end else begin
              state     <= IDLE;
              hold_cnt  <= '0;
              gnt       <= '0;
              gnt_valid <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/rr_grant_scheduler.md
Name: rr_grant_scheduler

Overview:
- 8-requester round-robin scheduler that owns the 8-to-3 priority encoder resource. It decides which requester drives the encoder and holds it there.
- Produces a registered one-hot grant, the matching 3-bit encoded grant id, and a valid flag.
- Limits how long one requester may hold the resource, so no requester starves.
- Sits between request sources and any downstream logic that consumes an encoded 3-bit index.

Parameters:
- N_REQ, 8, number of requesters. Fixed at 8; gnt_id is 3 bits.
- MAX_HOLD, 4, maximum consecutive cycles one grant is held. Legal range 1..16.
- HCW, $clog2(MAX_HOLD)+1, width of the hold counter (localparam).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- en  input  1  scheduler enable. Low blocks new grants and releases the current one.
- req  input  8  request vector; bit i = requester i wants the resource. Level-sensitive.
- gnt  output  8  one-hot grant (registered); all-zero when nothing is granted.
- gnt_id  output  3  binary index of the granted requester (registered). Holds its last value when gnt_valid=0.
- gnt_valid  output  1  high while any grant is active (registered).

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - gnt=8'h00, gnt_id=3'd0, gnt_valid=0.
  - Round-robin pointer ptr=3'd0, hold_cnt=0, state=IDLE.
  - Reset overrides en and req. Asserting it mid-grant drops the grant at that edge.
- State machine:
  - IDLE: if en=1 and req!=0, at the next edge grant the first set bit searching ptr, ptr+1, ... ptr+7 (mod 8). Then go to GRANT with hold_cnt=0. Otherwise stay in IDLE.
  - GRANT: hold gnt/gnt_id unchanged and increment hold_cnt while all of the following are true:
    - en=1
    - req[gnt_id]=1
    - hold_cnt < MAX_HOLD-1
  - Release event in GRANT (any of the above conditions false):
    - ptr <= gnt_id+1 (mod 8).
    - If en=1, re-arbitrate in the same cycle from gnt_id+1. The holder is searched last, so it is re-granted only if it is the sole requester. A new grant loads at the same edge with hold_cnt=0 and no idle bubble. If no requester qualifies, go to IDLE and clear gnt/gnt_valid.
    - If en=0, go to IDLE and clear gnt and gnt_valid.
- Latency:
  - Request to grant: 1 cycle from IDLE. Grant is visible after the first edge at which req is sampled.
  - Release to next grant: 0 bubble cycles.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt == (gnt_valid ? 1<<gnt_id : 0).
  - A grant never lasts more than MAX_HOLD cycles.
  - Any continuously requesting requester is granted within 7*MAX_HOLD+1 cycles.
- Boundary cases:
  - Wrap-around: search from ptr=7 continues to 0.
  - MAX_HOLD=1: the grant rotates every cycle among active requesters.
  - req dropping in the same cycle as hold expiry is treated as a single release.
  - en falling and req changing together: en has priority (release, no re-grant).
  - Requests arriving while in GRANT do not preempt the holder.
- Counters:
  - hold_cnt saturates at MAX_HOLD-1 and is never observed above it.
  - ptr is 3 bits and wraps naturally.

Test Plan:
- Reset/idle: rst_n=0 for 2 cycles with req=8'hFF, en=1. Expect gnt=0, gnt_valid=0, gnt_id=0. Release reset; the first edge after gives gnt=8'h01, gnt_id=0.
- Single requesters with MAX_HOLD=4: en=1, apply req=8'h01, 8'h02, 8'h04 ... 8'h80, each held 10 cycles with 1 idle cycle between.
  - Expect gnt_id=0,1,...,7 one cycle after each req.
  - Expect each grant to re-issue to the same requester every 4 cycles, with no gap (sole requester).
- Round-robin fairness: req=8'hFF constant, MAX_HOLD=4. Expect gnt_id sequence 0,1,2,...,7,0, each for exactly 4 cycles, gnt_valid continuously high.
- Early release and wrap: ptr at 6, req=8'h84 (bits 7 and 2). Expect grant to 7; drop req[7] after 2 cycles. The next edge gives gnt_id=2 directly, with no idle cycle.
- Enable control: grant active to requester 3, then drop en. The next edge gives gnt=0, gnt_valid=0. Restore en with req=8'h08: gnt_id=3 one cycle later.
- Reset mid-grant: while gnt=8'h10, pulse rst_n=0 for 1 cycle. At that edge expect outputs cleared and ptr=0; with req=8'h11, the next grant goes to requester 0.
